// File: rtl/fetch_pc_unit.sv
// Instruction-fetch / next-PC stage: fetches one word per request, executes it,
// then advances the PC sequentially or to a branch target; stops on the halt word.
module fetch_pc_unit #(
    parameter int unsigned       PC_W     = 64,
    parameter logic [PC_W-1:0]   RESET_PC = {PC_W{1'b0}},
    parameter logic [31:0]       HLT_WORD = 32'hD440_0000,
    parameter int unsigned       CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ack,
    input  logic             stall,
    input  logic             branch,
    input  logic             uncond_branch,
    input  logic             zero,
    input  logic [PC_W-1:0]  signext_imm,
    output logic [31:0]      instr,
    output logic [10:0]      opcode,
    output logic             instr_valid,
    output logic [PC_W-1:0]  pc_cur,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_EXEC = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [31:0]      r_instr;
    logic [CNT_W-1:0] r_retired;
    logic             w_latch;
    logic             w_retire;
    logic             w_taken;

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic plus latch/retire strobes
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_REQ: begin
                if (imem_ack) begin
                    w_latch = 1'b1;
                    if (imem_rdata == HLT_WORD) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_EXEC;
                    end
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // Branch decision; the select form keeps an unknown branch flag out of next_pc
    // whenever the unconditional flag is set.
    always_comb begin
        w_taken  = uncond_branch ? 1'b1 : (branch & zero);
        if (w_taken) begin
            w_pc_nxt = r_pc + (signext_imm << 2);
        end else begin
            w_pc_nxt = r_pc + PC_W'(4);
        end
    end

    // Program counter
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_pc <= RESET_PC;
        end else if (w_retire) begin
            r_pc <= w_pc_nxt;
        end else begin
            r_pc <= r_pc;
        end
    end

    // Current instruction latch
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_instr <= 32'h0000_0000;
        end else if (w_latch) begin
            r_instr <= imem_rdata;
        end else begin
            r_instr <= r_instr;
        end
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_retired <= {CNT_W{1'b0}};
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end else begin
            r_retired <= r_retired;
        end
    end

    // Request is gated by Reset so it drops without waiting for a clock edge
    assign imem_req    = (r_state == S_REQ) & ~Reset;
    assign imem_addr   = r_pc;
    assign pc_cur      = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:21];
    assign instr_valid = (r_state == S_EXEC);
    assign halted      = (r_state == S_HALT);
    assign retired     = r_retired;

endmodule
